// File: rtl/mac_acc_array_pkg.sv
// Shared constants, fusion-mode encoding and helpers for the MAC accumulator stage.
package mac_acc_array_pkg;

    localparam int unsigned MAC_LANES_DEF   = 4;
    localparam int unsigned MAC_INT_W_DEF   = 16;
    localparam int unsigned MAC_ACC_W_DEF   = 32;
    localparam int unsigned MAC_SHIFT_W_DEF = 16;

    typedef enum logic [1:0] {
        MAC_MODE_SINGLE = 2'd0,
        MAC_MODE_DUAL   = 2'd1,
        MAC_MODE_QUAD   = 2'd2,
        MAC_MODE_RSVD   = 2'd3
    } mac_mode_e;

    // Lanes fused per group for a raw mode value; the reserved code behaves as single.
    function automatic int unsigned mac_group_size(input logic [1:0] mode);
        case (mode)
            MAC_MODE_DUAL: return 32'd2;
            MAC_MODE_QUAD: return 32'd4;
            default:       return 32'd1;
        endcase
    endfunction

    // Fold the reserved code onto single so downstream logic sees three modes only.
    function automatic mac_mode_e mac_mode_norm(input logic [1:0] mode);
        case (mode)
            MAC_MODE_DUAL: return MAC_MODE_DUAL;
            MAC_MODE_QUAD: return MAC_MODE_QUAD;
            default:       return MAC_MODE_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/mac_acc_array_sat_add.sv
// Signed W-bit adder with overflow detect and optional clamp to the signed range.
module mac_acc_sat_add #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sat_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W-1:0] raw;
    logic         ovf;

    // Overflow when both operands share a sign and the raw sum does not.
    always_comb begin
        raw   = a_i + b_i;
        ovf   = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);
        sum_o = raw;
        if (ovf && sat_i) begin
            sum_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        ovf_o = ovf;
    end

endmodule

// File: rtl/mac_acc_array.sv
// Two-stage lane-fusing accumulator behind the MAC multiplier array:
// stage 1 combines partials per group, stage 2 accumulates or passes through.
module mac_acc_array
    import mac_acc_array_pkg::*;
#(
    parameter int unsigned LANES   = MAC_LANES_DEF,
    parameter int unsigned INT_W   = MAC_INT_W_DEF,
    parameter int unsigned ACC_W   = MAC_ACC_W_DEF,
    parameter int unsigned SHIFT_W = MAC_SHIFT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             cfg_mode,
    input  logic                   cfg_acc_en,
    input  logic                   cfg_sat,
    input  logic [LANES*ACC_W-1:0] cfg_init,
    input  logic                   load,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*INT_W-1:0] partial,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] out,
    output logic [LANES-1:0]       ovf
);

    localparam int unsigned WIDE = LANES * ACC_W;
    localparam int unsigned NG2  = LANES / 2;
    localparam int unsigned NG4  = LANES / 4;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDE-1:0]  s1_c_q, s1_c_d;
    mac_mode_e        s1_mode_q, s1_mode_d;
    logic             s1_acc_en_q, s1_acc_en_d;
    logic             s1_sat_q, s1_sat_d;

    // Stage 2 / accumulator registers
    logic             out_valid_q, out_valid_d;
    logic [WIDE-1:0]  out_q, out_d;
    logic [WIDE-1:0]  acc_q, acc_d;
    logic [LANES-1:0] ovf_q, ovf_d;

    // Handshake
    logic adv1, adv2, accept;

    // Combine datapath
    int unsigned      comb_f;
    logic [WIDE-1:0]  comb_c;
    logic [WIDE-1:0]  comb_grp;
    logic [WIDE-1:0]  comb_mask;
    logic [INT_W-1:0] comb_lane;
    logic [WIDE-1:0]  comb_sext;

    // Accumulate datapath
    logic [WIDE-1:0]  acc_base;
    logic [WIDE-1:0]  sum1, sum2, sum4, sum_sel;
    logic [LANES-1:0] ovf1;
    logic [NG2-1:0]   ovf2;
    logic [NG4-1:0]   ovf4;
    logic [LANES-1:0] ovf_sel;

    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = s1_valid_q && adv2;
    assign in_ready = !s1_valid_q || adv2;
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign ovf       = ovf_q;

    // Shift-and-add each group's sign-extended partials, truncated to the group width.
    always_comb begin
        comb_f    = mac_group_size(cfg_mode);
        comb_c    = '0;
        comb_grp  = '0;
        comb_lane = '0;
        comb_sext = '0;
        comb_mask = '1;
        comb_mask = comb_mask >> (WIDE - comb_f * ACC_W);
        for (int unsigned g = 0; g < LANES; g++) begin
            if (g < LANES / comb_f) begin
                comb_grp = '0;
                for (int unsigned k = 0; k < 4; k++) begin
                    if (k < comb_f) begin
                        comb_lane = partial[(g * comb_f + k) * INT_W +: INT_W];
                        comb_sext = {{(WIDE-INT_W){comb_lane[INT_W-1]}}, comb_lane};
                        comb_grp  = comb_grp + (comb_sext << (k * SHIFT_W));
                    end
                end
                comb_grp = comb_grp & comb_mask;
                comb_c   = comb_c | (comb_grp << (g * comb_f * ACC_W));
            end
        end
    end

    // A coinciding load replaces the accumulator operand so the add sees the init value.
    assign acc_base = load ? cfg_init : acc_q;

    // One adder per possible group in each mode; the captured mode selects the result.
    for (genvar g = 0; g < LANES; g++) begin : g_single
        mac_acc_sat_add #(.W(ACC_W)) u_add (
            .a_i   (acc_base[g*ACC_W +: ACC_W]),
            .b_i   (s1_c_q[g*ACC_W +: ACC_W]),
            .sat_i (s1_sat_q),
            .sum_o (sum1[g*ACC_W +: ACC_W]),
            .ovf_o (ovf1[g])
        );
    end

    for (genvar g = 0; g < NG2; g++) begin : g_dual
        mac_acc_sat_add #(.W(2*ACC_W)) u_add (
            .a_i   (acc_base[g*2*ACC_W +: 2*ACC_W]),
            .b_i   (s1_c_q[g*2*ACC_W +: 2*ACC_W]),
            .sat_i (s1_sat_q),
            .sum_o (sum2[g*2*ACC_W +: 2*ACC_W]),
            .ovf_o (ovf2[g])
        );
    end

    for (genvar g = 0; g < NG4; g++) begin : g_quad
        mac_acc_sat_add #(.W(4*ACC_W)) u_add (
            .a_i   (acc_base[g*4*ACC_W +: 4*ACC_W]),
            .b_i   (s1_c_q[g*4*ACC_W +: 4*ACC_W]),
            .sat_i (s1_sat_q),
            .sum_o (sum4[g*4*ACC_W +: 4*ACC_W]),
            .ovf_o (ovf4[g])
        );
    end

    // Pick the sum for the beat's mode and fan each group's overflow out to its lanes.
    always_comb begin
        sum_sel = sum1;
        ovf_sel = ovf1;
        case (s1_mode_q)
            MAC_MODE_DUAL: begin
                sum_sel = sum2;
                for (int unsigned i = 0; i < LANES; i++) ovf_sel[i] = ovf2[i/2];
            end
            MAC_MODE_QUAD: begin
                sum_sel = sum4;
                for (int unsigned i = 0; i < LANES; i++) ovf_sel[i] = ovf4[i/4];
            end
            default: begin
                sum_sel = sum1;
                ovf_sel = ovf1;
            end
        endcase
    end

    // Next-state for both stages, the accumulators and the sticky flags.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_c_d      = s1_c_q;
        s1_mode_d   = s1_mode_q;
        s1_acc_en_d = s1_acc_en_q;
        s1_sat_d    = s1_sat_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;

        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_c_d      = comb_c;
            s1_mode_d   = mac_mode_norm(cfg_mode);
            s1_acc_en_d = cfg_acc_en;
            s1_sat_d    = cfg_sat;
        end else if (adv1) begin
            s1_valid_d = 1'b0;
        end

        if (load) begin
            acc_d = cfg_init;
            ovf_d = '0;
        end

        if (adv1) begin
            out_valid_d = 1'b1;
            if (s1_acc_en_q) begin
                acc_d = sum_sel;
                ovf_d = (load ? '0 : ovf_q) | ovf_sel;
                out_d = sum_sel;
            end else begin
                out_d = s1_c_q;
            end
        end else if (adv2) begin
            out_valid_d = 1'b0;
        end
    end

    // Pipeline and accumulator state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_c_q      <= '0;
            s1_mode_q   <= MAC_MODE_SINGLE;
            s1_acc_en_q <= 1'b0;
            s1_sat_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_c_q      <= s1_c_d;
            s1_mode_q   <= s1_mode_d;
            s1_acc_en_q <= s1_acc_en_d;
            s1_sat_q    <= s1_sat_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_acc_array.sv
// Self-checking bench for mac_acc_array with an arithmetic reference model.
module tb_mac_acc_array;

    logic         clk;
    logic         rst_n;
    logic [1:0]   cfg_mode;
    logic         cfg_acc_en;
    logic         cfg_sat;
    logic [127:0] cfg_init;
    logic         load;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  partial;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dut_out;
    logic [3:0]   ovf;

    mac_acc_array #(
        .LANES   (4),
        .INT_W   (16),
        .ACC_W   (32),
        .SHIFT_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_mode   (cfg_mode),
        .cfg_acc_en (cfg_acc_en),
        .cfg_sat    (cfg_sat),
        .cfg_init   (cfg_init),
        .load       (load),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .partial    (partial),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (dut_out),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] out;
        logic [3:0]   ovf;
        int unsigned  cyc;
    } exp_t;

    exp_t         exp_q[$];
    logic [31:0]  seen_q[$];
    logic [127:0] m_acc;
    logic [3:0]   m_ovf;
    logic [127:0] last_out;
    logic [3:0]   last_ovf;
    logic         sampled_in_ready;
    logic         chk_lat;
    int unsigned  cyc;
    int           checks;
    int           errors;

    function automatic logic signed [255:0] sx(input logic [255:0] v, input int unsigned w);
        logic signed [255:0] t;
        t = v;
        t = t <<< (256 - w);
        t = t >>> (256 - w);
        return t;
    endfunction

    task automatic model_load(input logic [127:0] init);
        m_acc = init;
        m_ovf = '0;
    endtask

    // Reference: exact group sum, compared against the signed range of the group width.
    task automatic model_accept();
        int unsigned         f;
        int unsigned         gw;
        logic signed [255:0] c, a, s, mx, mn;
        logic [127:0]        pass;
        exp_t                e;
        f    = (cfg_mode == 2'd1) ? 2 : (cfg_mode == 2'd2) ? 4 : 1;
        gw   = f * 32;
        pass = '0;
        for (int unsigned g = 0; g < 4 / f; g++) begin
            c = '0;
            for (int unsigned k = 0; k < f; k++)
                c = c + (sx({240'b0, partial[(g*f+k)*16 +: 16]}, 16) <<< (k * 16));
            c = sx(c, gw);
            if (cfg_acc_en) begin
                a  = sx({128'b0, m_acc} >> (g * gw), gw);
                s  = a + c;
                mx = (256'sd1 <<< (gw - 1)) - 256'sd1;
                mn = -mx - 256'sd1;
                if (s > mx || s < mn) begin
                    for (int unsigned k = 0; k < f; k++) m_ovf[g*f+k] = 1'b1;
                    if (cfg_sat) s = (s > mx) ? mx : mn;
                end
                for (int unsigned k = 0; k < f; k++) m_acc[(g*f+k)*32 +: 32] = s[k*32 +: 32];
            end else begin
                for (int unsigned k = 0; k < f; k++) pass[(g*f+k)*32 +: 32] = c[k*32 +: 32];
            end
        end
        e.out = cfg_acc_en ? m_acc : pass;
        e.ovf = m_ovf;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // One clock: sample handshakes just before the edge, then advance to the next negedge.
    task automatic step();
        exp_t e;
        #1;
        sampled_in_ready = in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat cyc=%0d out=%h (no beat outstanding)", cyc, dut_out);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (dut_out !== e.out) begin
                    errors++;
                    $display("FAIL out_value cyc=%0d got=%h exp=%h", cyc, dut_out, e.out);
                end
                checks++;
                if (ovf !== e.ovf) begin
                    errors++;
                    $display("FAIL ovf_value cyc=%0d got=%b exp=%b", cyc, ovf, e.ovf);
                end
                if (chk_lat) begin
                    checks++;
                    if (cyc != e.cyc + 2) begin
                        errors++;
                        $display("FAIL latency got=%0d exp=%0d", cyc - e.cyc, 2);
                    end
                end
            end
            last_out = dut_out;
            last_ovf = ovf;
            seen_q.push_back(dut_out[31:0]);
        end
        if (in_valid && in_ready) model_accept();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        int unsigned n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout outstanding=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic pulse_load(input logic [127:0] init);
        cfg_init = init;
        load     = 1'b1;
        in_valid = 1'b0;
        step();
        model_load(init);
        load = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (dut_out !== 128'b0 || out_valid !== 1'b0 || ovf !== 4'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s got out=%h out_valid=%b ovf=%b in_ready=%b exp out=0 out_valid=0 ovf=0 in_ready=1",
                     tag, dut_out, out_valid, ovf, in_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        check_reset_state("reset_initial");
        rst_n = 1'b1;
        step();
        cfg_mode   = 2'd0;
        cfg_acc_en = 1'b1;
        cfg_sat    = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            partial = {$urandom, $urandom};
            step();
        end
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_midstream");
        exp_q.delete();
        model_load('0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check_reset_state("reset_no_stale");
    endtask

    task automatic test_single_acc();
        drain();
        cfg_mode   = 2'd0;
        cfg_acc_en = 1'b1;
        cfg_sat    = 1'b0;
        pulse_load('0);
        seen_q.delete();
        chk_lat  = 1'b1;
        in_valid = 1'b1;
        partial  = 64'd5; step();
        partial  = 64'd6; step();
        partial  = 64'd7; step();
        drain();
        chk_lat = 1'b0;
        checks++;
        if (seen_q.size() != 3 || seen_q[0] !== 32'd5 || seen_q[1] !== 32'd11 || seen_q[2] !== 32'd18) begin
            errors++;
            $display("FAIL single_acc_seq got n=%0d exp 5,11,18", seen_q.size());
        end
    endtask

    task automatic test_dual_pass();
        cfg_mode   = 2'd1;
        cfg_acc_en = 1'b0;
        in_valid   = 1'b1;
        partial    = 64'h0000_0000_0002_0001;
        step();
        drain();
        checks++;
        if (last_out[63:0] !== 64'h0000_0000_0002_0001) begin
            errors++;
            $display("FAIL dual_pos got=%h exp=%h", last_out[63:0], 64'h0000_0000_0002_0001);
        end
        in_valid = 1'b1;
        partial  = 64'h0000_0000_0000_FFFF;
        step();
        drain();
        checks++;
        if (last_out[63:0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL dual_neg got=%h exp=%h", last_out[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_sat_wrap();
        cfg_mode   = 2'd0;
        cfg_acc_en = 1'b1;
        cfg_sat    = 1'b1;
        pulse_load({96'b0, 32'h7FFF_FFF0});
        in_valid = 1'b1;
        partial  = 64'h20;
        step();
        drain();
        checks++;
        if (last_out[31:0] !== 32'h7FFF_FFFF || last_ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL sat got=%h ovf=%b exp=7fffffff ovf0=1", last_out[31:0], last_ovf);
        end
        in_valid = 1'b1;
        partial  = 64'h0;
        step();
        drain();
        checks++;
        if (last_ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got=%b exp=1", last_ovf[0]);
        end
        pulse_load({96'b0, 32'h7FFF_FFF0});
        checks++;
        if (ovf !== 4'b0) begin
            errors++;
            $display("FAIL ovf_cleared_by_load got=%b exp=0000", ovf);
        end
        cfg_sat  = 1'b0;
        in_valid = 1'b1;
        partial  = 64'h20;
        step();
        drain();
        checks++;
        if (last_out[31:0] !== 32'h8000_0010 || last_ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap got=%h ovf=%b exp=80000010 ovf0=1", last_out[31:0], last_ovf);
        end
    endtask

    task automatic test_load_coincide();
        cfg_mode   = 2'd2;
        cfg_acc_en = 1'b1;
        cfg_sat    = 1'b0;
        cfg_init   = 128'd100;
        model_load(128'd100);
        in_valid = 1'b1;
        partial  = 64'd3;
        step();
        in_valid = 1'b0;
        load     = 1'b1;
        step();
        load = 1'b0;
        drain();
        checks++;
        if (last_out !== 128'd103 || last_ovf !== 4'b0) begin
            errors++;
            $display("FAIL load_coincide got=%h ovf=%b exp=103 ovf=0", last_out, last_ovf);
        end
    endtask

    task automatic test_backpressure();
        cfg_mode   = 2'd0;
        cfg_acc_en = 1'b1;
        cfg_sat    = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            partial = {$urandom, $urandom};
            step();
            checks++;
            if (sampled_in_ready !== (i < 2)) begin
                errors++;
                $display("FAIL bp_in_ready cycle=%0d got=%b exp=%b", i, sampled_in_ready, (i < 2));
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            partial = {$urandom, $urandom};
            step();
        end
        drain();
    endtask

    task automatic test_random();
        logic [127:0] init;
        for (int b = 0; b < 8; b++) begin
            drain();
            for (int l = 0; l < 4; l++) begin
                case ($urandom_range(0, 2))
                    0:       init[l*32 +: 32] = 32'h7FFF_FF00 | $urandom_range(0, 255);
                    1:       init[l*32 +: 32] = 32'h8000_0000 | $urandom_range(0, 255);
                    default: init[l*32 +: 32] = $urandom;
                endcase
            end
            pulse_load(init);
            for (int i = 0; i < 40; i++) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                out_ready  = ($urandom_range(0, 2) != 0);
                cfg_mode   = 2'($urandom_range(0, 3));
                cfg_acc_en = 1'($urandom_range(0, 3) != 0);
                cfg_sat    = 1'($urandom_range(0, 1));
                partial    = {$urandom, $urandom};
                step();
            end
        end
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        chk_lat    = 1'b0;
        rst_n      = 1'b0;
        cfg_mode   = 2'd0;
        cfg_acc_en = 1'b0;
        cfg_sat    = 1'b0;
        cfg_init   = '0;
        load       = 1'b0;
        in_valid   = 1'b0;
        partial    = '0;
        out_ready  = 1'b1;
        last_out   = '0;
        last_ovf   = '0;
        model_load('0);
        repeat (2) @(negedge clk);
        test_reset();
        test_single_acc();
        test_dual_pass();
        test_sat_wrap();
        test_load_coincide();
        test_backpressure();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
